// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the serial frame receiver:
//   - DEFAULT_DATA_BITS : default MSB index of the received word
//   - state_e           : receiver FSM states
//   - cnt_width()       : width of the bit counter for a given DATA_BITS
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DEFAULT_DATA_BITS = 16;

    // IDLE  : no bit received since the last frame end
    // SHIFT : 1..DATA_BITS+1 bits received
    // OVER  : more than DATA_BITS+1 bits received (counter saturated)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    // Counter must reach DATA_BITS+2, so it needs to represent DATA_BITS+3 values.
    function automatic int cnt_width(input int data_bits);
        return $clog2(data_bits + 3);
    endfunction

endpackage

// File: rtl/shift_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer followed by a registered rising-edge pulse.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   in_i    : asynchronous input level
//   sync_o  : synchronized level (second synchronizer flop)
//   pulse_o : one-cycle registered pulse for each rising edge of in_i
//
// Input sampled high at clk edge N produces pulse_o high after edge N+2.
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic sync_o,
    output logic pulse_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       pulse_q;
    // Warm-up shift: prev_q only holds a real sample once warm_q[2] is set.
    // Without it an input already high at reset release would look like a
    // 0->1 transition against the reset value of prev_q.
    logic [2:0] warm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            warm_q  <= 3'b000;
        end else begin
            meta_q  <= in_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            warm_q  <= {warm_q[1:0], 1'b1};
            pulse_q <= sync_q & ~prev_q & warm_q[2];
        end
    end

    assign sync_o  = sync_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/shift_rx.sv
// -----------------------------------------------------------------------------
// shift_rx
// Receives MSB-first serial frames clocked by an external sclk and terminated
// by an external slat strobe, presenting each complete word on a valid/rdy
// output port.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   sclk  : external serial clock (async), data taken on its rising edge
//   sdat  : external serial data (async), MSB first
//   slat  : external latch strobe (async), rising edge ends a frame
//   rdy   : consumer ready; word transfers on a clk edge with valid && rdy
//   Q     : received word (DATA_BITS+1 bits), stable while valid
//   valid : Q holds an unconsumed word
//   ferr  : one-cycle pulse, frame ended with the wrong bit count
//   ovr   : one-cycle pulse, good frame dropped since previous word unconsumed
//   busy  : at least one bit received since the last frame end or reset
// -----------------------------------------------------------------------------
module shift_rx
    import shift_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               sdat,
    input  logic               slat,
    input  logic               rdy,
    output logic [DATA_BITS:0] Q,
    output logic               valid,
    output logic               ferr,
    output logic               ovr,
    output logic               busy
);

    localparam int                CNT_W    = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_OVER = CNT_W'(DATA_BITS + 2);

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = sclk, index 1 = slat
    // ------------------------------------------------------------------
    logic [1:0] ext_in;
    logic [1:0] ext_sync;
    logic [1:0] ext_pulse;

    assign ext_in = {slat, sclk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            sync_edge u_sync_edge (
                .clk     (clk),
                .rst     (rst),
                .in_i    (ext_in[gi]),
                .sync_o  (ext_sync[gi]),
                .pulse_o (ext_pulse[gi])
            );
        end
    endgenerate

    logic sclk_p;
    logic slat_p;

    assign sclk_p = ext_pulse[0];
    assign slat_p = ext_pulse[1];

    // sdat goes through the same two synchronizer flops plus one more stage so
    // that dat_al_q carries the sample taken alongside the sclk sample that
    // produced the current sclk_p.
    logic dat_meta_q;
    logic dat_sync_q;
    logic dat_al_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
            dat_al_q   <= 1'b0;
        end else begin
            dat_meta_q <= sdat;
            dat_sync_q <= dat_meta_q;
            dat_al_q   <= dat_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state. The shift is computed before the frame-end
    // decision so a bit arriving in the same cycle as slat is included.
    // ------------------------------------------------------------------
    logic [DATA_BITS:0] shift_q;
    logic [DATA_BITS:0] shift_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               frame_good;
    logic               load;

    logic [DATA_BITS:0] q_q;
    logic               valid_q;
    logic               ferr_q;
    logic               ovr_q;
    logic               busy_q;
    state_e             state_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (sclk_p) begin
            shift_d = {shift_q[DATA_BITS-1:0], dat_al_q};
            if (cnt_q != CNT_OVER) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        frame_good = (cnt_d == CNT_FULL);
        // A good frame is taken when the output slot is free or being freed
        // on this very edge.
        load       = slat_p && frame_good && (!valid_q || rdy);
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= slat_p ? '0 : cnt_d;

            ferr_q  <= slat_p && !frame_good;
            ovr_q   <= slat_p && frame_good && valid_q && !rdy;

            if (load) begin
                q_q     <= shift_d;
                valid_q <= 1'b1;
            end else if (valid_q && rdy) begin
                valid_q <= 1'b0;
            end

            if (slat_p) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sclk_p) begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (sclk_p && (cnt_d == CNT_OVER)) begin
                            state_q <= ST_OVER;
                        end
                    end
                    ST_OVER: begin
                        state_q <= ST_OVER;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q     = q_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign ovr   = ovr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shift_rx.sv
// -----------------------------------------------------------------------------
// tb_shift_rx
// Scoreboard bench for shift_rx. Stimulus tasks push the expected outcome of
// each frame (word / frame error / overrun) into the scoreboard; an
// independent monitor pops and compares whenever the DUT presents an output.
// -----------------------------------------------------------------------------
module tb_shift_rx;

    localparam int DB = 16;
    localparam int W  = DB + 1;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         sclk  = 1'b0;
    logic         sdat  = 1'b0;
    logic         slat  = 1'b0;
    logic         rdy   = 1'b1;
    logic [W-1:0] Q;
    logic         valid;
    logic         ferr;
    logic         ovr;
    logic         busy;

    always #5 clk = ~clk;

    shift_rx #(.DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst   (rst),
        .sclk  (sclk),
        .sdat  (sdat),
        .slat  (slat),
        .rdy   (rdy),
        .Q     (Q),
        .valid (valid),
        .ferr  (ferr),
        .ovr   (ovr),
        .busy  (busy)
    );

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] exp_words[$];
    int           exp_ferr = 0;
    int           exp_ovr  = 0;
    bit           mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (valid) begin
                if (exp_words.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got Q=%h expected no valid word", Q);
                end else begin
                    check(rdy ? "word" : "held_word", 32'(Q), 32'(exp_words[0]));
                    if (rdy) void'(exp_words.pop_front());
                end
            end
            if (ferr) begin
                tests++;
                if (exp_ferr > 0) exp_ferr--;
                else begin
                    fails++;
                    $display("FAIL unexpected_ferr: got ferr=1 expected 0");
                end
            end
            if (ovr) begin
                tests++;
                if (exp_ovr > 0) exp_ovr--;
                else begin
                    fails++;
                    $display("FAIL unexpected_ovr: got ovr=1 expected 0");
                end
            end
        end
    end

    // ---------------- reference model of a frame end ----------------
    // n bits ending in a frame: exactly W bits is a word, otherwise an error.
    // A word arriving while the previous one is still held and rdy is low is
    // an overrun and is dropped.
    task automatic model_frame_end(input logic [31:0] bits, input int n);
        if (n != W) exp_ferr++;
        else if (!rdy && exp_words.size() > 0) exp_ovr++;
        else exp_words.push_back(bits[W-1:0]);
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        @(negedge clk) sdat = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic latch(input logic [31:0] bits, input int n);
        repeat (3) @(negedge clk);
        model_frame_end(bits, n);
        slat = 1'b1;
        repeat (4) @(negedge clk);
        slat = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        send_bits(bits, n);
        latch(bits, n);
    endtask

    // Last sclk rising edge and slat rising edge in the same clk cycle.
    task automatic send_frame_fused(input logic [31:0] bits);
        send_bits(bits >> 1, W - 1);
        @(negedge clk) sdat = bits[0];
        repeat (3) @(negedge clk);
        model_frame_end(bits, W);
        sclk = 1'b1;
        slat = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        slat = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] data;
        int          n;
        int          lat;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_Q", 32'(Q), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(ferr), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);

        // Nominal frame, also checking busy tracking
        send_bits(32'h1A5A5 >> 14, 3);
        repeat (3) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'h1);
        send_bits(32'h1A5A5, 14);
        latch(32'h1A5A5, W);
        check("busy_after_frame", 32'(busy), 32'h0);

        // Latency from first clk edge sampling slat high to valid high
        send_bits(32'h0ABCD, W);
        repeat (3) @(negedge clk);
        model_frame_end(32'h0ABCD, W);
        slat = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid) break;
        end
        check("latency", 32'(lat), 32'd4);
        repeat (4) @(negedge clk);
        slat = 1'b0;
        repeat (8) @(negedge clk);

        // Short, long and empty frames
        send_frame(32'h0BEEF, 16);
        check("short_valid", 32'(valid), 32'h0);
        send_frame(32'h2AAAA, 18);
        send_frame(32'h0, 0);

        // Overrun: word held while rdy low, second good frame dropped
        @(posedge clk); #1 rdy = 1'b0;
        send_frame(32'h00001, W);
        send_frame(32'h1FFFE, W);
        check("ovr_hold_Q", 32'(Q), 32'h00001);
        check("ovr_hold_valid", 32'(valid), 32'h1);
        @(posedge clk); #1 rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_release_valid", 32'(valid), 32'h0);

        // Reset mid-frame, then a clean frame
        send_bits(32'hA5, 8);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(32'h15555, W);

        // Shift and latch in the same cycle
        send_frame_fused(32'h0F0F0);

        // sclk and slat held high through reset release
        @(negedge clk);
        sclk = 1'b1;
        slat = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("held_high_busy", 32'(busy), 32'h0);
        check("held_high_valid", 32'(valid), 32'h0);
        sclk = 1'b0;
        slat = 1'b0;
        repeat (6) @(negedge clk);
        send_frame(32'h12345, W);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            data = $urandom;
            case ($urandom_range(0, 9))
                0:       n = 15;
                1:       n = 16;
                2:       n = 18;
                3:       n = 19;
                default: n = W;
            endcase
            send_frame(data, n);
        end

        // Drain and confirm every expectation was seen
        repeat (20) @(negedge clk);
        check("pending_words", 32'(exp_words.size()), 32'd0);
        check("pending_ferr", 32'(exp_ferr), 32'd0);
        check("pending_ovr", 32'(exp_ovr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
